mt9v034_capture: RTL and testbench
==================================

# mt9v034_capture

Receives the MT9V034 parallel video output (FRAME_VALID, LINE_VALID, DOUT[9:0]) in the same 24 MHz domain that drives the camera's SYSCLK. It captures exactly one complete frame per request and emits an 8-bit pixel stream tagged with X/Y coordinates and start-of-frame and end-of-line markers. It sits between the camera pins and the downstream frame buffer or UART dump logic, and is the return path for the trigger/clock block.

## Interface
Parameters:
- MAX_COLS, 752, maximum active pixels per line; longer lines are truncated.
- MAX_ROWS, 480, maximum active lines per frame; further lines are dropped.

Ports:
- clk_24M  input  1  camera pixel clock domain (24 MHz); all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- cam_fv  input  1  camera FRAME_VALID.
- cam_lv  input  1  camera LINE_VALID.
- cam_dout  input  10  camera pixel data.
- cap_req  input  1  single-cycle pulse that arms capture of the next full frame.
- busy  output  1  high from accepted cap_req until frame end.
- pix_out  output  8  cam_dout[9:2] of the captured pixel.
- pix_valid  output  1  pix_out, pix_x and pix_y are valid this cycle.
- pix_x  output  10  column index, 0-based.
- pix_y  output  9  row index, 0-based.
- sof  output  1  coincident with the first pix_valid of the frame.
- eol  output  1  coincident with the last pix_valid of each line.
- frame_done  output  1  one-cycle pulse at frame end.
- rows_seen  output  9  line count of the last frame, held until the next frame_done.
- err_size  output  1  sticky; set on truncation or dropped lines, cleared by an accepted cap_req.

## Operation
- All cam_* inputs are registered once (stage S1) before use.
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH, CAPTURE.
  - IDLE: cap_req → WAIT_LOW, busy=1, err_size=0.
  - WAIT_LOW: S1 fv=0 → WAIT_HIGH. This discards any frame already in progress.
  - WAIT_HIGH: rising edge of S1 fv → CAPTURE, pix_y=0.
  - CAPTURE: falling edge of S1 fv → IDLE; frame_done=1, busy=0, rows_seen latched.
- cap_req while busy is ignored.
- Line handling in CAPTURE:
  - While S1 lv=1, each cycle is one pixel and the column counter increments.
  - On S1 lv falling edge, the row counter increments and the column counter clears.
  - Pixels with column ≥ MAX_COLS are not emitted and set err_size.
  - Lines with row ≥ MAX_ROWS are not emitted and set err_size.
- eol: asserted on the last emitted pixel of a line. This requires a one-pixel lookahead: the output is held one cycle so that it can be tagged when S1 lv falls, or when the column reaches MAX_COLS-1.
- fv falls while lv=1: the line is closed with eol on the held pixel, then frame_done.
- Zero-length frame (fv pulse with no lv): frame_done fires, rows_seen=0, no sof.
- rows_seen saturates at MAX_ROWS.

## Timing
- Latency: a pixel on cam_dout at edge n appears on pix_out at edge n+3 (S1, lookahead hold, output register).
- frame_done is asserted 3 cycles after S1 fv is sampled low: after the final pixel's eol, with no overlap.
- Reset values: busy=0, pix_valid=0, sof=0, eol=0, frame_done=0, pix_out=0, pix_x=0, pix_y=0, rows_seen=0, err_size=0; FSM=IDLE.
- reset_n asserted mid-frame: all outputs clear immediately (asynchronous). After release, the block waits in IDLE for a new cap_req.
- lv or fv glitches shorter than one clock are not filtered.

## Configuration
- CAP_DECIM_EN defined:
  - 2×2 subsampling: only even columns of even rows are emitted.
  - pix_x and pix_y report decimated indices (column/2, row/2).
  - eol is asserted on the last emitted even column.
  - rows_seen still counts raw lines.
- CAP_DECIM_EN undefined: every pixel is emitted as described above.

## Test plan
- Reset: hold reset_n=0 with cam_fv=1, cam_lv=1 → all outputs 0, no pix_valid; after release, no output until cap_req.
- Nominal 4×3 frame, dout=row*16+col shifted left by 2 → 12 pix_valid; sof on (0,0); eol at x=3 on each row; frame_done 3 cycles after fv falls; rows_seen=3; err_size=0.
- cap_req mid-frame → remainder of the current frame is ignored; the next full frame is captured starting with sof at (0,0).
- MAX_COLS=4, line of 6 pixels → 4 pixels emitted, eol at x=3, err_size=1; a following cap_req clears err_size.
- fv falls while lv=1 after 2 pixels of row 1 → eol on x=1, then frame_done; rows_seen=2.
- CAP_DECIM_EN, 4×4 frame → 4 pixels emitted at (0,0), (1,0), (0,1), (1,1); eol at x=1; rows_seen=4.

Source files
------------

// File: rtl/mt9v034_capture.sv
// mt9v034_capture: arms on cap_req and captures one complete MT9V034 frame.
// The output is an 8-bit pixel stream tagged with x/y, sof and eol.
// Optional build macro CAP_DECIM_EN enables 2x2 subsampling: even columns of
// even rows are emitted, with halved coordinates.
module mt9v034_capture #(
  parameter int unsigned MAX_COLS = 752,
  parameter int unsigned MAX_ROWS = 480
) (
  input  logic       clk_24M,
  input  logic       reset_n,
  input  logic       cam_fv,
  input  logic       cam_lv,
  input  logic [9:0] cam_dout,
  input  logic       cap_req,
  output logic       busy,
  output logic [7:0] pix_out,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       sof,
  output logic       eol,
  output logic       frame_done,
  output logic [8:0] rows_seen,
  output logic       err_size
);

  localparam logic [9:0] ColLim = 10'(MAX_COLS);
  localparam logic [9:0] RowLim = 10'(MAX_ROWS);
`ifdef CAP_DECIM_EN
  localparam logic [9:0] LastCol = 10'((MAX_COLS - 1) - ((MAX_COLS - 1) % 2));
`else
  localparam logic [9:0] LastCol = 10'(MAX_COLS - 1);
`endif

  typedef enum logic [1:0] {StIdle, StWaitLow, StWaitHigh, StCapture} state_e;
  state_e state_q, state_d;

  // S1 input stage plus one cycle of history for edge detection.
  logic       fv_q, lv_q, fv_p_q, lv_p_q;
  logic [7:0] dout_q;
  logic       unused_lsbs;
  assign unused_lsbs = ^cam_dout[1:0];

  logic [9:0] col_q, col_d, row_q, row_d;
  logic       sof_pend_q, sof_pend_d;
  // Lookahead hold stage: a pixel waits here until we know if it ends the line.
  logic       hold_valid_q, hold_valid_d, hold_sof_q, hold_sof_d, hold_last_q, hold_last_d;
  logic [7:0] hold_pix_q, hold_pix_d;
  logic [9:0] hold_x_q, hold_x_d;
  logic [8:0] hold_y_q, hold_y_d;
  // Output registers.
  logic       pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [7:0] pix_out_q, pix_out_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic [1:0] done_sr_q, done_sr_d;
  logic       frame_done_q, frame_done_d, busy_q, busy_d, err_q, err_d;
  logic [8:0] rows_seen_q, rows_seen_d;

  logic       fv_rise, fv_fall, eff_lv, eff_lv_p, accept, capturing;
  logic       pix_in, line_end, in_range, keep, emit, flush;
  logic [9:0] emit_x;
  logic [8:0] emit_y;

  assign fv_rise   = fv_q & ~fv_p_q;
  assign fv_fall   = ~fv_q & fv_p_q;
  // A line also closes when fv drops while lv is still high.
  assign eff_lv    = lv_q & fv_q;
  assign eff_lv_p  = lv_p_q & fv_p_q;
  assign accept    = (state_q == StIdle) & cap_req & ~busy_q;
  // Capture starts in the same cycle fv rises so an immediate lv is not lost.
  assign capturing = (state_q == StCapture) | ((state_q == StWaitHigh) & fv_rise);
  assign pix_in    = capturing & eff_lv;
  assign line_end  = capturing & eff_lv_p & ~eff_lv;
  assign in_range  = (col_q < ColLim) & (row_q < RowLim);
`ifdef CAP_DECIM_EN
  assign keep   = ~col_q[0] & ~row_q[0];
  assign emit_x = {1'b0, col_q[9:1]};
  assign emit_y = row_q[9:1];
`else
  assign keep   = 1'b1;
  assign emit_x = col_q;
  assign emit_y = row_q[8:0];
`endif
  assign emit  = pix_in & in_range & keep;
  assign flush = hold_valid_q & (emit | line_end | hold_last_q);

  // Next-state for FSM, counters, hold stage and output registers.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    sof_pend_d   = sof_pend_q;
    hold_valid_d = hold_valid_q;
    hold_sof_d   = hold_sof_q;
    hold_last_d  = hold_last_q;
    hold_pix_d   = hold_pix_q;
    hold_x_d     = hold_x_q;
    hold_y_d     = hold_y_q;
    pix_valid_d  = flush;
    sof_d        = flush & hold_sof_q;
    eol_d        = flush & (hold_last_q | line_end);
    pix_out_d    = pix_out_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    done_sr_d    = {done_sr_q[0], (state_q == StCapture) & fv_fall};
    frame_done_d = done_sr_q[1];
    busy_d       = busy_q;
    err_d        = err_q;
    rows_seen_d  = rows_seen_q;

    unique case (state_q)
      StIdle:     if (accept) state_d = StWaitLow;
      StWaitLow:  if (!fv_q) state_d = StWaitHigh;
      StWaitHigh: if (fv_rise) state_d = StCapture;
      StCapture:  if (fv_fall) state_d = StIdle;
    endcase

    if (accept || state_q == StWaitLow) begin
      col_d      = '0;
      row_d      = '0;
      sof_pend_d = 1'b1;
    end else if (line_end) begin
      col_d = '0;
      if (row_q < RowLim) row_d = row_q + 10'd1;
    end else if (pix_in && col_q < ColLim) begin
      col_d = col_q + 10'd1;
    end

    if (emit) begin
      sof_pend_d   = 1'b0;
      hold_valid_d = 1'b1;
      hold_sof_d   = sof_pend_q;
      hold_last_d  = (col_q == LastCol);
      hold_pix_d   = dout_q;
      hold_x_d     = emit_x;
      hold_y_d     = emit_y;
    end else if (flush) begin
      hold_valid_d = 1'b0;
    end

    if (flush) begin
      pix_out_d = hold_pix_q;
      pix_x_d   = hold_x_q;
      pix_y_d   = hold_y_q;
    end

    if (accept) begin
      busy_d = 1'b1;
      err_d  = 1'b0;
    end else begin
      if (done_sr_q[1]) busy_d = 1'b0;
      if (pix_in && !in_range) err_d = 1'b1;
    end
    if (done_sr_q[1]) rows_seen_d = row_q[8:0];
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk_24M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      fv_p_q       <= 1'b0;
      lv_p_q       <= 1'b0;
      dout_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      sof_pend_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_pix_q   <= '0;
      hold_x_q     <= '0;
      hold_y_q     <= '0;
      pix_valid_q  <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      pix_out_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      done_sr_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rows_seen_q  <= '0;
    end else begin
      state_q      <= state_d;
      fv_q         <= cam_fv;
      lv_q         <= cam_lv;
      fv_p_q       <= fv_q;
      lv_p_q       <= lv_q;
      dout_q       <= cam_dout[9:2];
      col_q        <= col_d;
      row_q        <= row_d;
      sof_pend_q   <= sof_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_sof_q   <= hold_sof_d;
      hold_last_q  <= hold_last_d;
      hold_pix_q   <= hold_pix_d;
      hold_x_q     <= hold_x_d;
      hold_y_q     <= hold_y_d;
      pix_valid_q  <= pix_valid_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      pix_out_q    <= pix_out_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      done_sr_q    <= done_sr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rows_seen_q  <= rows_seen_d;
    end
  end

  assign busy       = busy_q;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign frame_done = frame_done_q;
  assign rows_seen  = rows_seen_q;
  assign err_size   = err_q;

endmodule

// File: tb/tb_mt9v034_capture.sv
// Bench for mt9v034_capture with MAX_COLS=4, MAX_ROWS=4.
// Build with CAP_DECIM_EN defined to exercise the subsampling variant.
module tb_mt9v034_capture;

  logic       clk_24M = 1'b0;
  logic       reset_n, cam_fv, cam_lv, cap_req;
  logic [9:0] cam_dout;
  logic       busy, pix_valid, sof, eol, frame_done, err_size;
  logic [7:0] pix_out;
  logic [9:0] pix_x;
  logic [8:0] pix_y, rows_seen;

  always #5 clk_24M = ~clk_24M;

  mt9v034_capture #(.MAX_COLS(4), .MAX_ROWS(4)) dut (
    .clk_24M   (clk_24M),
    .reset_n   (reset_n),
    .cam_fv    (cam_fv),
    .cam_lv    (cam_lv),
    .cam_dout  (cam_dout),
    .cap_req   (cap_req),
    .busy      (busy),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sof       (sof),
    .eol       (eol),
    .frame_done(frame_done),
    .rows_seen (rows_seen),
    .err_size  (err_size)
  );

  typedef struct { int id; int x; int y; int pix; bit s; bit e; } vec_t;
  typedef struct { int x; int y; int pix; bit s; bit e; int cyc; } ev_t;
  vec_t tbl[$];
  ev_t  got[$];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, overlap = 0;
  int first_cyc = 0, fall_cyc = 0;

  always @(posedge clk_24M) cyc <= cyc + 1;

  // Record every output event away from the active edge.
  always @(negedge clk_24M) begin
    if (pix_valid) got.push_back(ev_t'{int'(pix_x), int'(pix_y), int'(pix_out), sof, eol, cyc});
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_done && pix_valid) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int id, input int x, input int y, input int pix,
                              input bit s, input bit e);
    tbl.push_back(vec_t'{id, x, y, pix, s, e});
  endfunction

  // Compare captured pixel events of one frame against the table rows for that id.
  task automatic check_frame(input int id);
    int n = 0;
    foreach (tbl[i]) begin
      if (tbl[i].id == id) begin
        if (n < got.size())
          chk($sformatf("frame%0d px%0d {x,y,pix,sof,eol}", id, n),
              (got[n].x << 20) | (got[n].y << 10) | (got[n].pix << 2) |
              (int'(got[n].s) << 1) | int'(got[n].e),
              (tbl[i].x << 20) | (tbl[i].y << 10) | (tbl[i].pix << 2) |
              (int'(tbl[i].s) << 1) | int'(tbl[i].e));
        n++;
      end
    end
    chk($sformatf("frame%0d pixel count", id), got.size(), n);
    got.delete();
  endtask

  task automatic step();
    @(posedge clk_24M);
    #1;
  endtask

  task automatic pulse_req();
    step();
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
  endtask

  // Drive one frame; pixel value (base + row*16 + col) sits in cam_dout[9:2].
  // cut > 0 drops fv and lv together after 'cut' pixels of the final row.
  task automatic drive_frame(input int rows, input int cols, input int cut, input int base,
                             input bit req_mid);
    step();
    cam_fv = 1'b1;
    step();
    step();
    for (int r = 0; r < rows; r++) begin
      int n;
      n = (cut > 0 && r == rows - 1) ? cut : cols;
      for (int c = 0; c < n; c++) begin
        step();
        cam_lv   = 1'b1;
        cam_dout = 10'((base + r * 16 + c) * 4);
        cap_req  = req_mid && r == 0 && c == 0;
        if (r == 0 && c == 0) first_cyc = cyc;
      end
      step();
      cap_req = 1'b0;
      cam_lv  = 1'b0;
      if (cut > 0 && r == rows - 1) begin
        cam_fv   = 1'b0;
        fall_cyc = cyc;
        return;
      end
      step();
      step();
    end
    step();
    cam_fv   = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic zero_frame();
    step();
    cam_fv = 1'b1;
    repeat (3) step();
    cam_fv   = 1'b0;
    fall_cyc = cyc;
  endtask

  // fv low is driven at cycle fall_cyc, sampled by S1 one edge later, done 3 after that.
  task automatic wait_done(input int want);
    int n = 0;
    while (done_cnt < want && n < 50) begin
      step();
      n++;
    end
    chk("frame_done count", done_cnt, want);
    chk("frame_done latency", done_cyc - fall_cyc, 4);
    repeat (2) step();
  endtask

  initial begin
    reset_n  = 1'b0;
    cam_fv   = 1'b1;
    cam_lv   = 1'b1;
    cam_dout = 10'h3ff;
    cap_req  = 1'b0;

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) add(2, c, r, r * 16 + c, r == 0 && c == 0, c == 3);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) add(3, c, r, 128 + r * 16 + c, r == 0 && c == 0, c == 3);
    for (int c = 0; c < 4; c++) add(4, c, 0, c, c == 0, c == 3);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) add(5, c, r, r * 16 + c, r == 0 && c == 0, c == 1);
    for (int c = 0; c < 4; c++) add(6, c, 0, c, c == 0, c == 3);
    add(6, 0, 1, 16, 1'b0, 1'b0);
    add(6, 1, 1, 17, 1'b0, 1'b1);
    add(8, 0, 0, 0, 1'b1, 1'b0);
    add(8, 1, 0, 2, 1'b0, 1'b1);
    add(8, 0, 1, 32, 1'b0, 1'b0);
    add(8, 1, 1, 34, 1'b0, 1'b1);

    repeat (3) @(posedge clk_24M);
    #2;
    chk("reset strobes", {busy, pix_valid, sof, eol, frame_done, err_size}, 0);
    chk("reset pix_out/x", {pix_out, pix_x}, 0);
    chk("reset pix_y/rows_seen", {pix_y, rows_seen}, 0);
    reset_n = 1'b1;
    cam_fv  = 1'b0;
    cam_lv  = 1'b0;

    // Without a request nothing is captured.
    drive_frame(2, 4, 0, 0, 1'b0);
    repeat (6) step();
    chk("unarmed pixels", got.size(), 0);
    chk("unarmed frame_done", done_cnt, 0);
    chk("unarmed busy", busy, 0);

`ifdef CAP_DECIM_EN
    pulse_req();
    drive_frame(4, 4, 0, 0, 1'b0);
    wait_done(1);
    chk("decim first pixel latency in range",
        got.size() > 0 && got[0].cyc - first_cyc >= 3 && got[0].cyc - first_cyc <= 4, 1);
    check_frame(8);
    chk("decim rows_seen", rows_seen, 4);
    chk("decim err_size", err_size, 0);
`else
    // Nominal 4x3 frame.
    pulse_req();
    chk("busy after req", busy, 1);
    drive_frame(3, 4, 0, 0, 1'b0);
    wait_done(1);
    chk("sof latency", got.size() > 0 ? got[0].cyc - first_cyc : -1, 3);
    check_frame(2);
    chk("4x3 rows_seen", rows_seen, 3);
    chk("4x3 err_size", err_size, 0);
    chk("4x3 busy end", busy, 0);

    // Request mid-frame: that frame is skipped, the next one is captured.
    drive_frame(3, 4, 0, 0, 1'b1);
    chk("midreq skipped pixels", got.size(), 0);
    drive_frame(3, 4, 0, 128, 1'b0);
    wait_done(2);
    check_frame(3);

    // 6-pixel line truncated to 4.
    pulse_req();
    drive_frame(1, 6, 0, 0, 1'b0);
    wait_done(3);
    check_frame(4);
    chk("trunc err_size", err_size, 1);
    chk("trunc rows_seen", rows_seen, 1);
    pulse_req();
    chk("err cleared by req", err_size, 0);

    // 5 lines with MAX_ROWS=4: last line dropped, rows_seen saturates.
    drive_frame(5, 2, 0, 0, 1'b0);
    wait_done(4);
    check_frame(5);
    chk("rowdrop err_size", err_size, 1);
    chk("rowdrop rows_seen", rows_seen, 4);

    // fv falls with lv high after 2 pixels of row 1.
    pulse_req();
    chk("err cleared again", err_size, 0);
    drive_frame(2, 4, 2, 0, 1'b0);
    wait_done(5);
    check_frame(6);
    chk("cut rows_seen", rows_seen, 2);

    // Asynchronous reset while armed clears outputs without a clock edge.
    pulse_req();
    chk("armed busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset rows_seen", rows_seen, 0);
    step();
    reset_n = 1'b1;
    zero_frame();
    repeat (6) step();
    chk("post-reset unarmed done", done_cnt, 5);

    // Zero-length frame.
    pulse_req();
    zero_frame();
    wait_done(6);
    chk("zero-length pixels", got.size(), 0);
    chk("zero-length rows_seen", rows_seen, 0);
`endif
    chk("frame_done overlaps pix_valid", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
